// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The state enum is also exported on the interface for debug.
package rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Pointer increment that wraps at the requester count, not at a power of two.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned reqcnt);
    return (ptr + 1 >= reqcnt) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters, downstream and the round-robin arbiter.
// A beat transfers on an edge where gnt_valid_o and ack_i are both high; ack_i with gnt_valid_o low carries nothing.
interface rr_arbiter_if #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = (REQCNT > 1) ? $clog2(REQCNT) : 1
);
  import rr_arbiter_pkg::*;

  logic [REQCNT-1:0]   req_i;
  logic                ack_i;
  logic                last_i;
  logic                gnt_valid_o;
  logic [REQCNT-1:0]   gnt_o;
  logic [REQWIDTH-1:0] gnt_num_o;
  logic [REQWIDTH-1:0] prior_o;
  arb_state_t          state_o;

  modport master (
    output req_i, ack_i, last_i,
    input  gnt_valid_o, gnt_o, gnt_num_o, prior_o, state_o
  );

  modport slave (
    input  req_i, ack_i, last_i,
    output gnt_valid_o, gnt_o, gnt_num_o, prior_o, state_o
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set request scanning from prior upward,
// wrapping modulo REQCNT.
module rr_pick #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = (REQCNT > 1) ? $clog2(REQCNT) : 1
) (
  input  logic [REQCNT-1:0]   req,
  input  logic [REQWIDTH-1:0] prior,
  output logic                found,
  output logic [REQWIDTH-1:0] num,
  output logic [REQCNT-1:0]   onehot
);

  localparam logic [REQWIDTH:0] LIMIT = (REQWIDTH+1)'(REQCNT);

  logic [2*REQCNT-1:0] doubled;
  logic [REQCNT-1:0]   rotated;
  logic [REQWIDTH:0]   offset;
  logic [REQWIDTH:0]   sum;

  // Rotating a doubled copy puts requester 'prior' at bit 0 without a modulo.
  assign doubled = {req, req};
  assign rotated = REQCNT'(doubled >> prior);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    sum    = '0;
    num    = '0;
    onehot = '0;
    for (int k = REQCNT - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = (REQWIDTH+1)'(k);
      end
    end
    sum = {1'b0, prior} + offset;
    if (sum >= LIMIT) sum = sum - LIMIT;
    if (found) begin
      num    = sum[REQWIDTH-1:0];
      onehot = REQCNT'(1) << sum[REQWIDTH-1:0];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered grant, packet locking and a rotating priority pointer.
// A grant is held until the acked last beat or a requester abort, then re-arbitrated in the same cycle.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = (REQCNT > 1) ? $clog2(REQCNT) : 1
) (
  input logic         clk_i,
  input logic         rst_i,
  rr_arbiter_if.slave bus
);

  arb_state_t          state;
  logic [REQWIDTH-1:0] prior;
  logic [REQWIDTH-1:0] prior_nxt;
  logic [REQWIDTH-1:0] pick_prior;
  logic [REQWIDTH-1:0] gnt_num;
  logic [REQCNT-1:0]   gnt;
  logic                owner_req;
  logic                pkt_done;
  logic                release_gnt;
  logic                pick_found;
  logic [REQWIDTH-1:0] pick_num;
  logic [REQCNT-1:0]   pick_onehot;

  assign owner_req   = |(bus.req_i & gnt);
  assign pkt_done    = bus.ack_i && bus.last_i;
  // An owner dropping its request with no beat in flight releases like a finished packet.
  assign release_gnt = (state == ARB_LOCKED) && (pkt_done || (!owner_req && !bus.ack_i));
  assign prior_nxt   = REQWIDTH'(rr_next(32'(gnt_num), REQCNT));
  assign pick_prior  = release_gnt ? prior_nxt : prior;

  rr_pick #(
    .REQCNT   (REQCNT),
    .REQWIDTH (REQWIDTH)
  ) u_pick (
    .req    (bus.req_i),
    .prior  (pick_prior),
    .found  (pick_found),
    .num    (pick_num),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ARB_IDLE;
      prior   <= '0;
      gnt     <= '0;
      gnt_num <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state   <= ARB_LOCKED;
            gnt     <= pick_onehot;
            gnt_num <= pick_num;
          end
        end
        ARB_LOCKED: begin
          if (release_gnt) begin
            prior <= prior_nxt;
            if (pick_found) begin
              gnt     <= pick_onehot;
              gnt_num <= pick_num;
            end else begin
              state   <= ARB_IDLE;
              gnt     <= '0;
              gnt_num <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.gnt_valid_o = (state == ARB_LOCKED);
  assign bus.gnt_o       = gnt;
  assign bus.gnt_num_o   = gnt_num;
  assign bus.prior_o     = prior;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (REQCNT 3, 1, 5) against an integer reference model,
// with directed scenarios followed by randomized traffic.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_if #(.REQCNT(3), .REQWIDTH(2)) if3 ();
  rr_arbiter_if #(.REQCNT(1), .REQWIDTH(1)) if1 ();
  rr_arbiter_if #(.REQCNT(5), .REQWIDTH(3)) if5 ();

  rr_arbiter #(.REQCNT(3), .REQWIDTH(2)) u_arb3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));
  rr_arbiter #(.REQCNT(1), .REQWIDTH(1)) u_arb1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  rr_arbiter #(.REQCNT(5), .REQWIDTH(3)) u_arb5 (.clk_i(clk), .rst_i(rst), .bus(if5.slave));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // id 0 -> REQCNT 3, id 1 -> REQCNT 1, id 2 -> REQCNT 5; m_gnt = -1 means no grant.
  int n_req [3] = '{3, 1, 5};
  int m_prior [3];
  int m_gnt [3];

  function automatic int ref_pick(input int id, input int req, input int p);
    for (int k = 0; k < n_req[id]; k++) begin
      int idx;
      idx = (p + k) % n_req[id];
      if (((req >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_prior[i] = 0;
      m_gnt[i]   = -1;
    end
  endtask

  task automatic model_step(input int id, input int req, input bit ack, input bit last);
    if (m_gnt[id] < 0) begin
      m_gnt[id] = ref_pick(id, req, m_prior[id]);
    end else if ((ack && last) || (((req >> m_gnt[id]) & 1) == 0 && !ack)) begin
      m_prior[id] = (m_gnt[id] + 1) % n_req[id];
      m_gnt[id]   = ref_pick(id, req, m_prior[id]);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int id);
    logic [31:0] v, g, nm, pr, st;
    int e;
    case (id)
      0: begin
        v = 32'(if3.gnt_valid_o); g = 32'(if3.gnt_o); nm = 32'(if3.gnt_num_o);
        pr = 32'(if3.prior_o); st = 32'(if3.state_o);
      end
      1: begin
        v = 32'(if1.gnt_valid_o); g = 32'(if1.gnt_o); nm = 32'(if1.gnt_num_o);
        pr = 32'(if1.prior_o); st = 32'(if1.state_o);
      end
      default: begin
        v = 32'(if5.gnt_valid_o); g = 32'(if5.gnt_o); nm = 32'(if5.gnt_num_o);
        pr = 32'(if5.prior_o); st = 32'(if5.state_o);
      end
    endcase
    e = m_gnt[id];
    check($sformatf("d%0d_valid", id), v,  32'(e >= 0));
    check($sformatf("d%0d_gnt", id),   g,  (e >= 0) ? 32'(1 << e) : 32'd0);
    check($sformatf("d%0d_num", id),   nm, (e >= 0) ? 32'(e) : 32'd0);
    check($sformatf("d%0d_prior", id), pr, 32'(m_prior[id]));
    check($sformatf("d%0d_state", id), st, 32'(e >= 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_all(input int id, input int req, input bit ack, input bit last);
    if3.req_i  = (id == 0) ? 3'(req) : 3'd0;
    if3.ack_i  = (id == 0) && ack;
    if3.last_i = (id == 0) && last;
    if1.req_i  = (id == 1) ? 1'(req) : 1'b0;
    if1.ack_i  = (id == 1) && ack;
    if1.last_i = (id == 1) && last;
    if5.req_i  = (id == 2) ? 5'(req) : 5'd0;
    if5.ack_i  = (id == 2) && ack;
    if5.last_i = (id == 2) && last;
  endtask

  // One clock: drive instance 'id', idle the others, advance the model, compare #1 after the edge.
  task automatic step(input int id, input int req, input bit ack, input bit last);
    drive_all(id, req, ack, last);
    @(posedge clk);
    for (int k = 0; k < 3; k++)
      model_step(k, (k == id) ? req : 0, (k == id) && ack, (k == id) && last);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic do_reset();
    drive_all(0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int exp_fair_num [6]   = '{0, 1, 2, 0, 1, 2};
  int exp_fair_prior [6] = '{0, 1, 2, 0, 1, 2};
  int exp_n5 [5]         = '{0, 4, 0, 4, 0};

  initial begin
    model_reset();
    do_reset();

    // Reset / idle
    for (int i = 0; i < 10; i++) step(0, 0, 1'b0, 1'b0);
    check("idle_valid", 32'(if3.gnt_valid_o), 32'd0);
    check("idle_prior", 32'(if3.prior_o), 32'd0);

    // Fairness: all requesting, single-beat packets
    for (int i = 0; i < 6; i++) begin
      step(0, 7, 1'b1, 1'b1);
      check($sformatf("fair_num%0d", i), 32'(if3.gnt_num_o), 32'(exp_fair_num[i]));
      check($sformatf("fair_prior%0d", i), 32'(if3.prior_o), 32'(exp_fair_prior[i]));
      check($sformatf("fair_valid%0d", i), 32'(if3.gnt_valid_o), 32'd1);
    end

    // Packet lock: requester 1 holds across 4 beats while requester 2 joins
    do_reset();
    step(0, 2, 1'b0, 1'b0);
    check("lock_first", 32'(if3.gnt_num_o), 32'd1);
    step(0, 2, 1'b1, 1'b0);
    check("lock_b1", 32'(if3.gnt_num_o), 32'd1);
    step(0, 6, 1'b1, 1'b0);
    check("lock_b2", 32'(if3.gnt_num_o), 32'd1);
    step(0, 6, 1'b1, 1'b0);
    check("lock_b3", 32'(if3.gnt_num_o), 32'd1);
    step(0, 6, 1'b1, 1'b1);
    check("lock_next", 32'(if3.gnt_num_o), 32'd2);
    check("lock_prior", 32'(if3.prior_o), 32'd2);

    // Abort: requester 0 drops without ack
    do_reset();
    step(0, 1, 1'b0, 1'b0);
    check("abort_first", 32'(if3.gnt_num_o), 32'd0);
    step(0, 4, 1'b0, 1'b0);
    check("abort_num", 32'(if3.gnt_num_o), 32'd2);
    check("abort_prior", 32'(if3.prior_o), 32'd1);

    // Async reset mid-packet, then restart from pointer 0
    check("pre_rst_valid", 32'(if3.gnt_valid_o), 32'd1);
    do_reset();
    check("rst_valid", 32'(if3.gnt_valid_o), 32'd0);
    step(0, 6, 1'b0, 1'b0);
    check("post_rst_num", 32'(if3.gnt_num_o), 32'd1);

    // Spurious ack in IDLE
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1'b1, 1'b1);
    check("spur_valid", 32'(if3.gnt_valid_o), 32'd0);
    check("spur_prior", 32'(if3.prior_o), 32'd0);

    // REQCNT = 1: grant follows req with no bubble between packets
    do_reset();
    step(1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1'b1, (i % 2) == 1);
      check($sformatf("n1_valid%0d", i), 32'(if1.gnt_valid_o), 32'd1);
      check($sformatf("n1_prior%0d", i), 32'(if1.prior_o), 32'd0);
    end

    // REQCNT = 5: requesters 0 and 4 alternate across the wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(2, 5'b10001, 1'b1, 1'b1);
      check($sformatf("n5_num%0d", i), 32'(if5.gnt_num_o), 32'(exp_n5[i]));
    end

    // Randomized traffic per instance, with one mid-run reset each
    for (int id = 0; id < 3; id++) begin
      int req;
      do_reset();
      req = 0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) req = $urandom_range(0, (1 << n_req[id]) - 1);
        step(id, req, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        if (i == 150) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
